// File: rtl/vector_mem_req_arbiter_pkg.sv
// Shared types for the vector load/store memory request path: the request
// and control records plus default sizing for the memory request arbiter.
package vector_mem_req_arbiter_pkg;

   localparam int MEM_ARB_PORTS      = 4;
   localparam int MEM_REQ_FIFO_DEPTH = 8;
   localparam int CORE_ID_WIDTH      = 4;
   localparam int ACCESS_ID_WIDTH    = 8;
   localparam int ADDR_WIDTH         = 32;
   localparam int DATA_WIDTH         = 32;

   typedef struct packed {
      logic                       vld;
      logic [CORE_ID_WIDTH-1:0]   core_id;
      logic [ACCESS_ID_WIDTH-1:0] access_id;
      logic                       we;
      logic [ADDR_WIDTH-1:0]      addr;
      logic [DATA_WIDTH-1:0]      data;
   } request_t;

   typedef struct packed {
      logic        vld;
      logic [3:0]  opcode;
      logic [31:0] arg;
   } cntrl_req_t;

   typedef logic [$clog2(MEM_ARB_PORTS)-1:0] port_id_t;

   localparam request_t REQ_IDLE = '{default: 1'b0};

endpackage

// File: rtl/vector_mem_req_arbiter_if.sv
// Bundle of requester, memory and response signals around the arbiter.
// The slave side is the arbiter; the master side is its environment.
interface vector_mem_req_arbiter_if
   import vector_mem_req_arbiter_pkg::*;
#(
   parameter int NUM_PORTS = MEM_ARB_PORTS
);

   request_t [NUM_PORTS-1:0] req_in;
   logic     [NUM_PORTS-1:0] req_grant;
   request_t                 mem_req;
   logic                     mem_ready;
   request_t                 mem_rsp;
   request_t [NUM_PORTS-1:0] rsp_out;

   modport master (
      output req_in, mem_ready, mem_rsp,
      input  req_grant, mem_req, rsp_out
   );

   modport slave (
      input  req_in, mem_ready, mem_rsp,
      output req_grant, mem_req, rsp_out
   );

endinterface

// File: rtl/vector_mem_req_arbiter_fifo.sv
// Show-ahead request queue: the head entry is read straight out of
// registered storage, so it is visible the cycle after it is pushed.
module vector_req_fifo
   import vector_mem_req_arbiter_pkg::*;
#(
   parameter int FIFO_DEPTH = MEM_REQ_FIFO_DEPTH,
   localparam int PTR_WIDTH = $clog2(FIFO_DEPTH)
)(
   input  logic               clk,
   input  logic               reset,
   input  logic               push,
   input  request_t           push_data,
   input  logic               pop,
   output request_t           head,
   output logic               full,
   output logic               empty,
   output logic [PTR_WIDTH:0] count
);

   request_t               mem_q [FIFO_DEPTH];
   request_t               mem_d [FIFO_DEPTH];
   logic [PTR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PTR_WIDTH:0]     count_q, count_d;
   logic                   push_ok_s;
   logic                   pop_ok_s;

   assign full  = (count_q == (PTR_WIDTH+1)'(FIFO_DEPTH));
   assign empty = (count_q == {(PTR_WIDTH+1){1'b0}});
   assign count = count_q;
   assign head  = mem_q[rd_ptr_q];

   // Next storage, pointers and occupancy; pointers wrap naturally at a power of two.
   always_comb begin
      push_ok_s = push && !full;
      pop_ok_s  = pop && !empty;
      mem_d     = mem_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      if (push_ok_s) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = wr_ptr_q + PTR_WIDTH'(1);
      end else begin
         wr_ptr_d        = wr_ptr_q;
      end
      if (pop_ok_s) begin
         rd_ptr_d = rd_ptr_q + PTR_WIDTH'(1);
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({push_ok_s, pop_ok_s})
         2'b10:   count_d = count_q + (PTR_WIDTH+1)'(1);
         2'b01:   count_d = count_q - (PTR_WIDTH+1)'(1);
         default: count_d = count_q;
      endcase
   end

   // Queue state registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= REQ_IDLE;
         end
         wr_ptr_q <= {PTR_WIDTH{1'b0}};
         rd_ptr_q <= {PTR_WIDTH{1'b0}};
         count_q  <= {(PTR_WIDTH+1){1'b0}};
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/vector_mem_req_arbiter.sv
// Round-robin arbiter between the vector load/store units and memory: stamps
// accepted requests with their source port, queues them, and demuxes responses.
module vector_mem_req_arbiter
   import vector_mem_req_arbiter_pkg::*;
#(
   parameter int NUM_PORTS     = MEM_ARB_PORTS,
   parameter int FIFO_DEPTH    = MEM_REQ_FIFO_DEPTH,
   parameter int PORT_ID_WIDTH = $clog2(NUM_PORTS)
)(
   input  logic                     clk,
   input  logic                     reset,
   vector_mem_req_arbiter_if.slave  bus
);

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   logic [PORT_ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
   logic [PORT_ID_WIDTH-1:0] winner_s;
   logic [PORT_ID_WIDTH-1:0] cand_id_s;
   logic [PORT_ID_WIDTH-1:0] rsp_dst_s;
   int                       cand_s;
   logic                     found_s;
   logic                     hit_s;
   logic                     grant_s;
   logic                     grant_en_q, grant_en_d;
   logic [NUM_PORTS-1:0]     grant_vec_s;
   request_t                 push_data_s;
   request_t                 fifo_head_s;
   request_t                 mem_req_s;
   logic                     fifo_full_s;
   logic                     fifo_empty_s;
   logic                     pop_s;
   logic [CNT_W-1:0]         fifo_count_s;
   logic                     rsp_hit_s;
   request_t [NUM_PORTS-1:0] rsp_out_q, rsp_out_d;

   // Round-robin search from rr_ptr; a full queue blocks the grant even if it pops this cycle.
   always_comb begin
      winner_s  = rr_ptr_q;
      found_s   = 1'b0;
      cand_s    = 0;
      cand_id_s = {PORT_ID_WIDTH{1'b0}};
      hit_s     = 1'b0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         cand_s    = int'(rr_ptr_q) + i;
         cand_s    = (cand_s >= NUM_PORTS) ? cand_s - NUM_PORTS : cand_s;
         cand_id_s = PORT_ID_WIDTH'(cand_s);
         hit_s     = !found_s && bus.req_in[cand_id_s].vld;
         winner_s  = hit_s ? cand_id_s : winner_s;
         found_s   = found_s | hit_s;
      end
      grant_s    = found_s && !fifo_full_s && grant_en_q;
      grant_en_d = 1'b1;
      grant_vec_s = {NUM_PORTS{1'b0}};
      grant_vec_s[winner_s] = grant_s;
      push_data_s = bus.req_in[winner_s];
      push_data_s.core_id = CORE_ID_WIDTH'(winner_s);
      if (grant_s) begin
         rr_ptr_d = (int'(winner_s) == NUM_PORTS - 1) ? {PORT_ID_WIDTH{1'b0}}
                                                       : winner_s + PORT_ID_WIDTH'(1);
      end else begin
         rr_ptr_d = rr_ptr_q;
      end
   end

   vector_req_fifo #(
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (grant_s),
      .push_data (push_data_s),
      .pop       (pop_s),
      .head      (fifo_head_s),
      .full      (fifo_full_s),
      .empty     (fifo_empty_s),
      .count     (fifo_count_s)
   );

   // Present the queue head to memory; its stored vld bit is replaced by occupancy.
   always_comb begin
      mem_req_s     = fifo_head_s;
      mem_req_s.vld = (fifo_count_s != {CNT_W{1'b0}});
      pop_s         = !fifo_empty_s && bus.mem_ready;
   end

   // Response demux; destinations beyond the last port are dropped.
   always_comb begin
      rsp_hit_s = bus.mem_rsp.vld && (bus.mem_rsp.core_id < CORE_ID_WIDTH'(NUM_PORTS));
      rsp_dst_s = bus.mem_rsp.core_id[PORT_ID_WIDTH-1:0];
      for (int p = 0; p < NUM_PORTS; p++) begin
         rsp_out_d[p] = (rsp_hit_s && (rsp_dst_s == PORT_ID_WIDTH'(p))) ? bus.mem_rsp : REQ_IDLE;
      end
   end

   // Arbiter pointer, grant enable and response registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rr_ptr_q   <= {PORT_ID_WIDTH{1'b0}};
         grant_en_q <= 1'b0;
         rsp_out_q  <= {NUM_PORTS{REQ_IDLE}};
      end else begin
         rr_ptr_q   <= rr_ptr_d;
         grant_en_q <= grant_en_d;
         rsp_out_q  <= rsp_out_d;
      end
   end

   assign bus.req_grant = grant_vec_s;
   assign bus.mem_req   = mem_req_s;
   assign bus.rsp_out   = rsp_out_q;

endmodule

// File: doc/vector_mem_req_arbiter.md
Name: vector_mem_req_arbiter

Overview:
- Sits directly downstream of the per-lane vector load/store units and upstream of the memory interface.
- Round-robin arbitrates NUM_PORTS request_t streams and stamps each accepted request with its source port in core_id.
- Queues accepted requests in a request FIFO and presents them to memory with a valid/ready handshake.
- Routes each memory response back to the port named by its core_id.

Parameters:
- NUM_PORTS, 4, number of load/store unit requesters (2..8).
- FIFO_DEPTH, 8, request queue entries (power of two, >=2).
- PORT_ID_WIDTH, $clog2(NUM_PORTS), width of port index; must be <= core_id field width.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-low reset.
- req_in  input  request_t [NUM_PORTS]  per-port memory request; vld held until granted.
- req_grant  output  [NUM_PORTS]  one-hot acceptance pulse, same cycle as capture.
- mem_req  output  request_t  head-of-queue request to memory.
- mem_ready  input  1  memory accepts mem_req this cycle.
- mem_rsp  input  request_t  memory response; vld for one cycle; core_id carries the destination port.
- rsp_out  output  request_t [NUM_PORTS]  per-port response, one-cycle vld pulse.

Behaviour:
- Reset clears the following:
  - FIFO (count=0, rd_ptr=wr_ptr=0).
  - rr_ptr=0.
  - All rsp_out='0.
  - mem_req.vld=0.
  - req_grant=0.
- Reset mid-operation discards queued requests and in-flight responses.
- Grant (combinational from registered state and req_in):
  - Candidates are ports with req_in[p].vld=1.
  - The winner is the first candidate searching from rr_ptr upward, mod NUM_PORTS.
  - req_grant[winner]=1 only when count<FIFO_DEPTH. No grant when full, even if a pop occurs the same cycle.
  - At most one grant bit is set.
- Capture: on a grant edge, push req_in[winner] with core_id overwritten by winner (zero-extended). rr_ptr <= (winner+1) mod NUM_PORTS.
- rr_ptr is unchanged when there is no grant.
- Requesters advance their request on the edge where they see req_grant, so no request is double-accepted.
- Memory side:
  - mem_req = FIFO head, with vld = (count!=0). The FIFO is show-ahead and registered storage.
  - Pop when mem_req.vld && mem_ready.
  - mem_req is held stable while vld && !mem_ready.
- Latency: grant at cycle t gives mem_req.vld at t+1 at the earliest (empty FIFO).
- Simultaneous push and pop: count unchanged; ordering preserved (strict FIFO).
- Pointers wrap mod FIFO_DEPTH; count is PORT-independent and $clog2(FIFO_DEPTH)+1 bits wide.
- Response path (registered, 1 cycle):
  - When mem_rsp.vld, rsp_out[mem_rsp.core_id] <= mem_rsp with vld=1. All other ports get vld=0.
  - If core_id>=NUM_PORTS, the response is dropped and all vld=0.
  - The next cycle without mem_rsp.vld clears rsp_out vld.
  - Back-to-back responses produce back-to-back pulses.
  - The response path is independent of the request path; both may be active in the same cycle.

Decomposition:
- The shared package holds request_t and cntrl_req_t (unchanged).
- Add to the package: MEM_ARB_PORTS and MEM_REQ_FIFO_DEPTH defaults, and a port_id_t typedef.
- Natural sub-module: vector_req_fifo. It is a synchronous show-ahead FIFO of request_t with push, pop, full, empty, count, and the same clk/reset.
- The arbiter, core_id stamping and response demux stay in the top module.

Test Plan:
- Single requester: port0 holds vld with addr=0x100 for 3 successive requests (access_id 0,1,2).
  - Expect grants on consecutive cycles.
  - Expect mem_req seen in order with core_id=0.
  - With mem_ready=1, mem_req.vld first at grant+1.
- Round-robin: ports 0, 1 and 3 all hold vld continuously from reset.
  - Expect grant order 0, 1, 3, 0, 1, 3.
  - Expect core_id 0, 1, 3 respectively on mem_req.
- Back-pressure: mem_ready=0 with 2 ports requesting.
  - Expect exactly 8 grants, then req_grant=0 with mem_req held stable.
  - Raise mem_ready for 1 cycle: 1 pop, and a new grant only on the following cycle.
- Response routing: mem_rsp.vld with core_id=2 and data=0xDEAD.
  - Expect rsp_out[2].vld=1 with data=0xDEAD one cycle later; all other ports vld=0.
  - Expect vld=0 on the next cycle.
- Invalid destination: NUM_PORTS=4, mem_rsp core_id=5 -> no rsp_out vld on any port.
- Reset mid-operation: assert reset with 5 entries queued and 2 ports requesting.
  - Expect mem_req.vld=0, req_grant=0 and count=0.
  - After release, the first grant goes to the lowest requesting port (rr_ptr=0).
